fp_div_iter: RTL and testbench

Parametrised, iterative IEEE-754 floating-point divider with a valid/ready handshake on both sides. It is the sequential successor of the half-precision combinational divider in the FP ALU. Exponent and fraction widths are parameters, so one block serves half and single precision. A restoring radix-2 mantissa divider replaces the single-cycle `/`. The block adds round-to-nearest-even, exception flags and correct special-case handling, and sits in the ALU's multi-cycle operation slot.

---
 rtl/fp_div_iter.sv | 181 ++++++++++++++++++
 tb/tb_fp_div_iter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 divider, restoring radix-2 mantissa loop.
// RNE rounding, DAZ/FTZ, special operands resolved at accept.
module fp_div_iter #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [EXP_W+MAN_W:0]       a,
   input  logic [EXP_W+MAN_W:0]       b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [EXP_W+MAN_W:0]       result,
   output logic [4:0]                 flags
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int QW   = MAN_W + 3;
   localparam int EW   = EXP_W + 2;
   localparam int CW   = $clog2(QW);
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [CW-1:0] C_END = CW'(QW - 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
   state_t state, state_nx;

   logic             sgn;
   logic             byp;
   logic [EW-1:0]    exp_r;
   logic [MAN_W:0]   mb;
   logic [MAN_W+1:0] rem;
   logic [QW-1:0]    quo;
   logic [CW-1:0]    cnt;

   logic             a_s, b_s, s_in;
   logic [EXP_W-1:0] a_e, b_e;
   logic [MAN_W-1:0] a_f, b_f;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   assign a_s = a[W-1];
   assign b_s = b[W-1];
   assign a_e = a[W-2:MAN_W];
   assign b_e = b[W-2:MAN_W];
   assign a_f = a[MAN_W-1:0];
   assign b_f = b[MAN_W-1:0];
   assign s_in = a_s ^ b_s;

   assign a_nan  = (&a_e) && (|a_f);
   assign b_nan  = (&b_e) && (|b_f);
   assign a_inf  = (&a_e) && !(|a_f);
   assign b_inf  = (&b_e) && !(|b_f);
   // exponent zero covers subnormals as well (DAZ)
   assign a_zero = (a_e == '0);
   assign b_zero = (b_e == '0);

   localparam logic [W-1:0] QNAN =
      {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic         sp_hit;
   logic [W-1:0] sp_res;
   logic [4:0]   sp_flg;

   always_comb begin
      sp_hit = 1'b1;
      sp_res = '0;
      sp_flg = '0;
      priority case (1'b1)
         a_nan || b_nan: begin
            sp_res    = QNAN;
            sp_flg[4] = (a_nan && !a_f[MAN_W-1]) ||
                        (b_nan && !b_f[MAN_W-1]);
         end
         (a_inf && b_inf) || (a_zero && b_zero): begin
            sp_res = QNAN;
            sp_flg = 5'b10000;
         end
         b_zero: begin
            sp_res = {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            sp_flg = 5'b01000;
         end
         a_inf: sp_res = {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         b_inf: sp_res = {s_in, {(W-1){1'b0}}};
         a_zero: sp_res = {s_in, {(W-1){1'b0}}};
         default: sp_hit = 1'b0;
      endcase
   end

   logic             ge;
   logic [MAN_W+1:0] diff;

   assign ge   = rem >= {1'b0, mb};
   assign diff = ge ? rem - {1'b0, mb} : rem;

   logic             hi, g, st, inc;
   logic [MAN_W:0]   m;
   logic [MAN_W+1:0] mr;
   logic [EW-1:0]    e0, e1;
   logic [MAN_W-1:0] frac;
   logic [W-1:0]     rd_res;
   logic [4:0]       rd_flg;

   always_comb begin
      hi   = quo[QW-1];
      m    = hi ? quo[QW-1:2] : quo[QW-2:1];
      g    = hi ? quo[1] : quo[0];
      st   = (hi && quo[0]) || (|rem);
      e0   = hi ? exp_r : exp_r - EW'(1);
      inc  = g && (st || m[0]);
      mr   = {1'b0, m} + (MAN_W+2)'(inc);
      e1   = mr[MAN_W+1] ? e0 + EW'(1) : e0;
      frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
      rd_res = {sgn, e1[EXP_W-1:0], frac};
      rd_flg = {4'b0000, g || st};
      if (!e1[EW-1] && e1 >= E_MAX) begin
         rd_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rd_flg = 5'b00101;
      end else if (e1[EW-1] || e1 == '0) begin
         rd_res = {sgn, {(W-1){1'b0}}};
         rd_flg = 5'b00011;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (in_valid) state_nx = sp_hit ? ROUND : DIVIDE;
         DIVIDE: if (cnt == C_END) state_nx = ROUND;
         ROUND:  state_nx = DONE;
         DONE:   if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sgn    <= 1'b0;
         byp    <= 1'b0;
         exp_r  <= '0;
         mb     <= '0;
         rem    <= '0;
         quo    <= '0;
         cnt    <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               sgn    <= s_in;
               byp    <= sp_hit;
               exp_r  <= EW'(a_e) - EW'(b_e) + EW'(BIAS);
               mb     <= {1'b1, b_f};
               rem    <= {1'b0, 1'b1, a_f};
               quo    <= '0;
               cnt    <= '0;
               result <= sp_res;
               flags  <= sp_flg;
            end
            DIVIDE: begin
               rem <= {diff[MAN_W:0], 1'b0};
               quo <= {quo[QW-2:0], ge};
               cnt <= cnt + CW'(1);
            end
            ROUND: if (!byp) begin
               result <= rd_res;
               flags  <= rd_flg;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: directed vectors for fp_div_iter, half and single
// precision instances with hand-computed quotients and flags.
module tb_fp_div_iter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        h_in_valid = 1'b0;
   logic        h_in_ready;
   logic [15:0] h_a = '0;
   logic [15:0] h_b = '0;
   logic        h_out_valid;
   logic        h_out_ready = 1'b1;
   logic [15:0] h_result;
   logic [4:0]  h_flags;

   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [31:0] s_a = '0;
   logic [31:0] s_b = '0;
   logic        s_out_valid;
   logic        s_out_ready = 1'b1;
   logic [31:0] s_result;
   logic [4:0]  s_flags;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fp_div_iter u_half (
      .clk(clk), .rst_n(rst_n),
      .in_valid(h_in_valid), .in_ready(h_in_ready),
      .a(h_a), .b(h_b),
      .out_valid(h_out_valid), .out_ready(h_out_ready),
      .result(h_result), .flags(h_flags)
   );

   fp_div_iter #(.EXP_W(8), .MAN_W(23)) u_single (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .result(s_result), .flags(s_flags)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_h(output int lat);
      lat = 0;
      while (!h_out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic op(input string tag, input logic [15:0] av,
                     input logic [15:0] bv, input logic [15:0] er,
                     input logic [4:0] ef, input int elat);
      int lat;
      @(negedge clk);
      check({tag, "_rdy"}, 32'(h_in_ready), 32'd1);
      h_a = av; h_b = bv; h_in_valid = 1'b1; h_out_ready = 1'b1;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      wait_h(lat);
      check({tag, "_lat"}, 32'(lat), 32'(elat));
      check({tag, "_res"}, 32'(h_result), 32'(er));
      check({tag, "_flg"}, 32'(h_flags), 32'(ef));
      @(posedge clk); #1;
      check({tag, "_idle"}, 32'(h_in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int seen;
      #1;
      check("rst_rdy", 32'(h_in_ready), 32'd1);
      check("rst_vld", 32'(h_out_valid), 32'd0);
      check("rst_res", 32'(h_result), 32'd0);
      check("rst_flg", 32'(h_flags), 32'd0);
      #12 rst_n = 1'b1;

      op("third",  16'h3C00, 16'h4200, 16'h3555, 5'b00001, 14);
      op("six2",   16'h4600, 16'h4000, 16'h4200, 5'b00000, 14);
      op("dz",     16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 1);
      op("z0",     16'h0000, 16'h0000, 16'h7E00, 5'b10000, 1);
      op("ninf",   16'hFC00, 16'h3C00, 16'hFC00, 5'b00000, 1);
      op("ovf",    16'h7BFF, 16'h3800, 16'h7C00, 5'b00101, 14);
      op("unf",    16'h0400, 16'h4000, 16'h0000, 5'b00011, 14);
      op("snan",   16'h7D00, 16'h3C00, 16'h7E00, 5'b10000, 1);
      op("qnan",   16'h3C00, 16'h7E00, 16'h7E00, 5'b00000, 1);
      op("finf",   16'hBC00, 16'h7C00, 16'h8000, 5'b00000, 1);
      op("ii",     16'h7C00, 16'hFC00, 16'h7E00, 5'b10000, 1);
      op("daz",    16'h0001, 16'h3C00, 16'h0000, 5'b00000, 1);

      // back-pressure, then a request pending across the acknowledge
      @(negedge clk);
      h_a = 16'h3C00; h_b = 16'h4200; h_in_valid = 1'b1;
      h_out_ready = 1'b0;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      wait_h(lat);
      check("bp_lat", 32'(lat), 32'd14);
      h_a = 16'h4600; h_b = 16'h4000; h_in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_res", 32'(h_result), 32'h3555);
         check("bp_rdy", 32'(h_in_ready), 32'd0);
         check("bp_vld", 32'(h_out_valid), 32'd1);
      end
      h_out_ready = 1'b1;
      @(posedge clk); #1;
      check("rel_vld", 32'(h_out_valid), 32'd0);
      check("rel_rdy", 32'(h_in_ready), 32'd1);
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      check("take_rdy", 32'(h_in_ready), 32'd0);
      wait_h(lat);
      check("take_lat", 32'(lat), 32'd14);
      check("take_res", 32'(h_result), 32'h4200);
      @(posedge clk); #1;

      // reset in the middle of the divide loop
      @(negedge clk);
      h_a = 16'h3C00; h_b = 16'h4200; h_in_valid = 1'b1;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("ar_vld", 32'(h_out_valid), 32'd0);
      check("ar_rdy", 32'(h_in_ready), 32'd1);
      check("ar_res", 32'(h_result), 32'd0);
      check("ar_flg", 32'(h_flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (h_out_valid) seen = 1;
      end
      check("ar_novld", 32'(seen), 32'd0);
      op("neg", 16'hC000, 16'h4000, 16'hBC00, 5'b00000, 14);

      // single precision instance
      @(negedge clk);
      s_a = 32'h3F800000; s_b = 32'h40400000; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      check("sp_lat", 32'(lat), 32'd27);
      check("sp_res", s_result, 32'h3EAAAAAB);
      check("sp_flg", 32'(s_flags), 32'd1);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
